// File: rtl/dac_spi_tx_if.sv
// dac_spi_tx_if: request strobe, status and DAC pin bundle for dac_spi_tx.
//
// Signals:
//   dac_din     code to send, meaningful only while dac_dvalid=1
//   dac_dvalid  single-cycle request strobe
//   dac_busy    frame in progress or a request is pending
//   dac_done    one-cycle pulse when spi_cs_n rises (DAC has latched)
//   dac_drop    one-cycle pulse when a pending request was overwritten
//   spi_cs_n    DAC chip select, active low
//   spi_sck     SPI clock, mode 0
//   spi_sdi     serial data, MSB first
//   dbg_state   current FSM state of the transmitter (IDLE=0, SHIFT=1, CSH=2)
//
// Handshake: there is no ready. A request is a one-cycle dac_dvalid pulse and
// is always taken on the clock edge where dac_dvalid=1: started at once when
// the transmitter is idle, otherwise parked in a single-entry pending slot.
// A second request arriving while the slot is full replaces the older one and
// is reported by dac_drop. dac_din is ignored whenever dac_dvalid=0.
//
// Modports: master = request source (acquisition FSM), slave = dac_spi_tx.

interface dac_spi_tx_if #(
    parameter int DAC_DATA_W = 10
);
    logic [DAC_DATA_W-1:0] dac_din;
    logic                  dac_dvalid;
    logic                  dac_busy;
    logic                  dac_done;
    logic                  dac_drop;
    logic                  spi_cs_n;
    logic                  spi_sck;
    logic                  spi_sdi;
    logic [1:0]            dbg_state;

    modport master (
        output dac_din, dac_dvalid,
        input  dac_busy, dac_done, dac_drop, spi_cs_n, spi_sck, spi_sdi, dbg_state
    );

    modport slave (
        input  dac_din, dac_dvalid,
        output dac_busy, dac_done, dac_drop, spi_cs_n, spi_sck, spi_sdi, dbg_state
    );
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises DAC codes into 16-bit MCP48x2-style SPI frames
// ({DAC_CMD, code, 2'b00}, MSB first, SPI mode 0, latched on CS rise).
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  dac_spi_tx_if.slave: request strobe/data in, status pulses and
//        SPI pins out, FSM state for debug
//
// Timing is fixed: CS is low for FRAME_W*DAC_SCK_DIV clocks starting the
// cycle after acceptance, then high for CS_HIGH_CYC clocks before the next
// frame may start. All outputs are registered.

module dac_spi_tx #(
    parameter int         DAC_DATA_W  = 10,
    parameter int         DAC_SCK_DIV = 8,
    parameter logic [3:0] DAC_CMD     = 4'b0011,
    parameter int         CS_HIGH_CYC = 2
) (
    input logic         clk,
    input logic         rst,
    dac_spi_tx_if.slave bus
);

    localparam int FRAME_W = DAC_DATA_W + 6;
    localparam int HALF    = DAC_SCK_DIV / 2;
    localparam int DIV_W   = (DAC_SCK_DIV > 2) ? $clog2(DAC_SCK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int CSH_W   = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CSH   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CSH_W-1:0]      csh_cnt_q, csh_cnt_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic [DAC_DATA_W-1:0] pend_q, pend_d;
    logic                  pend_valid_q, pend_valid_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sck_q, sck_d;
    logic                  sdi_q, sdi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  drop_q, drop_d;

    logic                  start;
    logic [DAC_DATA_W-1:0] start_word;
    logic                  csh_last;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        csh_cnt_d    = csh_cnt_q;
        frame_d      = frame_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        cs_n_d       = cs_n_q;
        sck_d        = sck_q;
        sdi_d        = sdi_q;
        done_d       = 1'b0;
        drop_d       = 1'b0;
        start        = 1'b0;
        start_word   = bus.dac_din;
        csh_last     = (csh_cnt_q == CSH_W'(CS_HIGH_CYC - 1));

        case (state_q)
            IDLE: begin
                // Pending slot is always empty here, so a strobe starts directly.
                if (bus.dac_dvalid) begin
                    start = 1'b1;
                end
            end

            SHIFT: begin
                if (bus.dac_dvalid) begin
                    pend_d       = bus.dac_din;
                    pend_valid_d = 1'b1;
                    drop_d       = pend_valid_q;
                end

                div_cnt_d = div_cnt_q + 1'b1;
                if (div_cnt_q == DIV_W'(HALF - 1)) begin
                    sck_d = 1'b1;
                end
                // End of a bit period: SCK falls and SDI moves together.
                if (div_cnt_q == DIV_W'(DAC_SCK_DIV - 1)) begin
                    sck_d     = 1'b0;
                    div_cnt_d = '0;
                    if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
                        cs_n_d    = 1'b1;
                        done_d    = 1'b1;
                        sdi_d     = 1'b0;
                        csh_cnt_d = '0;
                        state_d   = CSH;
                    end else begin
                        frame_d   = {frame_q[FRAME_W-2:0], 1'b0};
                        sdi_d     = frame_q[FRAME_W-2];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            CSH: begin
                if (!csh_last) begin
                    csh_cnt_d = csh_cnt_q + 1'b1;
                    if (bus.dac_dvalid) begin
                        pend_d       = bus.dac_din;
                        pend_valid_d = 1'b1;
                        drop_d       = pend_valid_q;
                    end
                end else if (pend_valid_q) begin
                    // Older request goes out first; a strobe arriving now simply
                    // refills the slot being vacated, so nothing is dropped.
                    start        = 1'b1;
                    start_word   = pend_q;
                    pend_valid_d = bus.dac_dvalid;
                    if (bus.dac_dvalid) begin
                        pend_d = bus.dac_din;
                    end
                end else if (bus.dac_dvalid) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            frame_d   = {DAC_CMD, start_word, 2'b00};
            sdi_d     = frame_d[FRAME_W-1];
            cs_n_d    = 1'b0;
            sck_d     = 1'b0;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = SHIFT;
        end

        busy_d = (state_d != IDLE) || pend_valid_d;
    end

    // Reset drops CS immediately; the DAC discards the partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            csh_cnt_q    <= '0;
            frame_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            sdi_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            csh_cnt_q    <= csh_cnt_d;
            frame_q      <= frame_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            cs_n_q       <= cs_n_d;
            sck_q        <= sck_d;
            sdi_q        <= sdi_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.spi_cs_n  = cs_n_q;
    assign bus.spi_sck   = sck_q;
    assign bus.spi_sdi   = sdi_q;
    assign bus.dac_busy  = busy_q;
    assign bus.dac_done  = done_q;
    assign bus.dac_drop  = drop_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: self-checking bench for dac_spi_tx.
// Two instances: defaults (SCK_DIV=8, CS_HIGH=2) and a fast one
// (SCK_DIV=2, CS_HIGH=1). One monitor watches whichever is selected, rebuilds
// each frame from SDI on SCK rises and compares against the expected queue.

module tb_dac_spi_tx;

    localparam int W = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever @(posedge clk) cyc++;

    dac_spi_tx_if #(.DAC_DATA_W(W)) if1 ();
    dac_spi_tx_if #(.DAC_DATA_W(W)) if2 ();

    dac_spi_tx u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    dac_spi_tx #(
        .DAC_SCK_DIV (2),
        .CS_HIGH_CYC (1)
    ) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    // ---------------- monitor mux ----------------
    logic sel = 1'b0;
    logic m_cs, m_sck, m_sdi, m_busy, m_done, m_drop;
    assign m_cs   = sel ? if2.spi_cs_n : if1.spi_cs_n;
    assign m_sck  = sel ? if2.spi_sck  : if1.spi_sck;
    assign m_sdi  = sel ? if2.spi_sdi  : if1.spi_sdi;
    assign m_busy = sel ? if2.dac_busy : if1.dac_busy;
    assign m_done = sel ? if2.dac_done : if1.dac_done;
    assign m_drop = sel ? if2.dac_drop : if1.dac_drop;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];
    int fall_q[$], rise_q[$], done_q[$], drop_q[$], brise_q[$], bfall_q[$];
    int pulses;
    int exp_half;
    int exp_drops;
    int t0 = 0;
    logic mon_en = 1'b0;

    int sched_c[$];
    logic [W-1:0] sched_v[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_ev(input string tag, input int q[$], input int n, input int e0, input int e1);
        check({tag, "_count"}, 32'(q.size()), 32'(n));
        if (n > 0 && q.size() > 0) check({tag, "_0"}, 32'(q[0]), 32'(e0));
        if (n > 1 && q.size() > 1) check({tag, "_1"}, 32'(q[1]), 32'(e1));
    endtask

    // ---------------- monitor ----------------
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;
    logic [15:0] shreg = '0;
    int bit_n = 0;
    int hi_start = 0;
    int rel_c;

    initial forever begin
        @(negedge clk);
        rel_c = cyc - t0;
        if (mon_en) begin
            if (prev_cs && !m_cs) begin
                fall_q.push_back(rel_c);
                shreg = '0;
                bit_n = 0;
            end
            if (!prev_cs && m_cs && !rst) begin
                rise_q.push_back(rel_c);
                check("frame_bits", 32'(bit_n), 32'd16);
                if (exp_q.size() > 0) check("frame", 32'(shreg), 32'(exp_q.pop_front()));
                else check("frame_unexpected", 32'(exp_q.size()), 32'd1);
            end
            if (!prev_sck && m_sck) begin
                hi_start = rel_c;
                shreg = {shreg[14:0], m_sdi};
                bit_n++;
                check("sck_in_frame", 32'(m_cs), 32'd0);
            end
            if (prev_sck && !m_sck) begin
                pulses++;
                check("sck_high_len", 32'(rel_c - hi_start), 32'(exp_half));
            end
            if (m_done) done_q.push_back(rel_c);
            if (m_drop) drop_q.push_back(rel_c);
            if (!prev_busy && m_busy) brise_q.push_back(rel_c);
            if (prev_busy && !m_busy) bfall_q.push_back(rel_c);
        end
        prev_cs   = m_cs;
        prev_sck  = m_sck;
        prev_busy = m_busy;
    end

    // ---------------- driver ----------------
    task automatic drive_in(input logic v, input logic [W-1:0] d);
        if1.dac_dvalid = sel ? 1'b0 : v;
        if1.dac_din    = d;
        if2.dac_dvalid = sel ? v : 1'b0;
        if2.dac_din    = d;
    endtask

    task automatic add(input int c, input logic [W-1:0] v);
        sched_c.push_back(c);
        sched_v.push_back(v);
    endtask

    // Runs cycles 0..ncyc from the current negedge. The reference model tracks
    // the last CS-high clock of the frame on the wire (m_end) and whether a
    // request is parked, and pushes the frames that must appear on the pins.
    task automatic run(input int ncyc, input int rst_at);
        int   m_end;
        logic m_pend;
        int   flen;
        flen = sel ? (16 * 2 + 1) : (16 * 8 + 2);
        exp_half = sel ? 1 : 4;
        m_end = -1;
        m_pend = 1'b0;
        exp_drops = 0;
        pulses = 0;
        fall_q.delete(); rise_q.delete(); done_q.delete();
        drop_q.delete(); brise_q.delete(); bfall_q.delete();
        t0 = cyc;
        mon_en = 1'b1;
        for (int c = 0; c <= ncyc; c++) begin
            logic         hit;
            logic [W-1:0] d;
            logic [15:0]  fr;
            hit = 1'b0;
            d = W'($urandom);
            foreach (sched_c[i]) if (sched_c[i] == c) begin
                hit = 1'b1;
                d = sched_v[i];
            end
            fr = {4'b0011, d, 2'b00};
            if (hit) begin
                if (m_end < c) begin
                    exp_q.push_back(fr);
                    m_end = c + flen;
                end else if (c == m_end) begin
                    exp_q.push_back(fr);
                    m_end = c + flen;
                end else if (m_pend) begin
                    void'(exp_q.pop_back());
                    exp_q.push_back(fr);
                    exp_drops++;
                end else begin
                    exp_q.push_back(fr);
                    m_pend = 1'b1;
                end
            end else if (c == m_end && m_pend) begin
                m_end = c + flen;
                m_pend = 1'b0;
            end
            drive_in(hit, d);
            if (rst_at >= 0 && c == rst_at) begin
                #1 rst = 1'b1;
                #1;
                check("abort_cs_n", 32'(m_cs), 32'd1);
                check("abort_sck", 32'(m_sck), 32'd0);
                check("abort_busy", 32'(m_busy), 32'd0);
                check("abort_done", 32'(m_done), 32'd0);
                exp_q.delete();
                m_end = -1;
                m_pend = 1'b0;
            end
            if (rst_at >= 0 && c == rst_at + 3) rst = 1'b0;
            @(negedge clk);
        end
        drive_in(1'b0, '0);
        mon_en = 1'b0;
        sched_c.delete();
        sched_v.delete();
        check("exp_left", 32'(exp_q.size()), 32'd0);
        check("drop_total", 32'(drop_q.size()), 32'(exp_drops));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive_in(1'b0, '0);
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(if1.spi_cs_n), 32'd1);
        check("rst_sck", 32'(if1.spi_sck), 32'd0);
        check("rst_sdi", 32'(if1.spi_sdi), 32'd0);
        check("rst_busy", 32'(if1.dac_busy), 32'd0);
        check("rst_done", 32'(if1.dac_done), 32'd0);
        check("rst_drop", 32'(if1.dac_drop), 32'd0);
        check("rst2_cs_n", 32'(if2.spi_cs_n), 32'd1);
        check("rst2_busy", 32'(if2.dac_busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single frame, defaults
        add(0, 10'h2AB);
        run(140, -1);
        check_ev("t1_cs_fall", fall_q, 1, 1, 0);
        check_ev("t1_cs_rise", rise_q, 1, 129, 0);
        check_ev("t1_done", done_q, 1, 129, 0);
        check_ev("t1_busy_rise", brise_q, 1, 1, 0);
        check_ev("t1_busy_fall", bfall_q, 1, 131, 0);
        check("t1_sck_pulses", 32'(pulses), 32'd16);

        // second request pending during first frame
        add(0, 10'h3FF);
        add(50, 10'h000);
        run(270, -1);
        check_ev("t2_cs_fall", fall_q, 2, 1, 131);
        check_ev("t2_cs_rise", rise_q, 2, 129, 259);
        check_ev("t2_done", done_q, 2, 129, 259);
        check_ev("t2_drop", drop_q, 0, 0, 0);
        check_ev("t2_busy_fall", bfall_q, 1, 261, 0);
        check("t2_sck_pulses", 32'(pulses), 32'd32);

        // overwrite of pending request
        add(0, 10'h001);
        add(10, 10'h002);
        add(20, 10'h003);
        run(270, -1);
        check_ev("t3_drop", drop_q, 1, 21, 0);
        check_ev("t3_cs_fall", fall_q, 2, 1, 131);

        // strobe on the last CS-high clock with pending empty
        add(0, 10'h100);
        add(130, 10'h0AA);
        run(270, -1);
        check_ev("t4_cs_fall", fall_q, 2, 1, 131);
        check_ev("t4_busy_fall", bfall_q, 1, 261, 0);
        check_ev("t4_drop", drop_q, 0, 0, 0);

        // reset mid-frame, then a clean frame
        add(0, 10'h155);
        run(80, 60);
        check_ev("t5_done", done_q, 0, 0, 0);
        check_ev("t5_cs_fall", fall_q, 1, 1, 0);
        check_ev("t5_busy_fall", bfall_q, 1, 61, 0);
        add(0, 10'h2AB);
        run(140, -1);
        check_ev("t5b_done", done_q, 1, 129, 0);
        check("t5b_sck_pulses", 32'(pulses), 32'd16);

        // fast instance
        sel = 1'b1;
        @(negedge clk);
        add(0, 10'h155);
        run(40, -1);
        check_ev("t6_cs_fall", fall_q, 1, 1, 0);
        check_ev("t6_cs_rise", rise_q, 1, 33, 0);
        check_ev("t6_done", done_q, 1, 33, 0);
        check_ev("t6_busy_fall", bfall_q, 1, 34, 0);
        check("t6_sck_pulses", 32'(pulses), 32'd16);
        sel = 1'b0;
        @(negedge clk);

        // random codes and spacing on the default instance
        for (int i = 0; i < 6; i++) add(i * 60 + $urandom_range(0, 20), W'($urandom));
        run(700, -1);
        check("t7_busy_end", 32'(if1.dac_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- Serialises DAC gain/idle words into SPI frames for the external 10-bit VGA-control DAC (MCP48x2-style: 16-bit frame, CS-rise latch, LDAC tied low on the board).
- Sits directly downstream of the acquisition FSM. Consumes its dac_din/dac_dvalid pulse and drives the DAC pins.
- Frame timing is fixed and deterministic, because the acquisition gain-update threshold budgets exactly DAC_SCK_DIV*(DAC_DATA_W+6) clocks per update.

Parameters:
DAC_DATA_W, 10, DAC data width
DAC_SCK_DIV, 8, system clocks per SCK period; even, >=2
DAC_CMD, 4'b0011, frame header bits [15:12]: channel A, don't-care, GA=1 (1x), SHDN=1 (active)
CS_HIGH_CYC, 2, minimum clocks spi_cs_n stays high between frames; >=1
FRAME_W, DAC_DATA_W+6, bits per frame (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
dac_din  in  DAC_DATA_W  DAC code; sampled when dac_dvalid=1
dac_dvalid  in  1  single-cycle request strobe
dac_busy  out  1  frame in progress or pending
dac_done  out  1  one-cycle pulse when spi_cs_n rises (DAC latched)
dac_drop  out  1  one-cycle pulse when a pending request is overwritten
spi_cs_n  out  1  DAC chip select, active low
spi_sck  out  1  SPI clock, mode 0 (idle low, DAC samples on rise)
spi_sdi  out  1  serial data, MSB first

Behaviour:
- Clock and reset: clk is the system clock; rst is asynchronous, active-high.
- All outputs are registered. Reset values: spi_cs_n=1, spi_sck=0, spi_sdi=0, dac_busy=0, dac_done=0, dac_drop=0. Pending buffer is emptied, FSM goes to IDLE.
- Frame contents: {DAC_CMD, dac_din, 2'b00}, loaded into a FRAME_W shift register on acceptance.
- FSM states IDLE, SHIFT, CSH.
- IDLE:
  - dac_dvalid sampled at edge 0 (cycle 0).
  - Cycle 1: spi_cs_n=0, spi_sdi=frame MSB, dac_busy=1. State is SHIFT, div_cnt=0, bit_cnt=0.
- SHIFT:
  - div_cnt counts 0..DAC_SCK_DIV-1.
  - spi_sck goes 1 after div_cnt==DAC_SCK_DIV/2-1 and goes 0 after div_cnt==DAC_SCK_DIV-1. Each bit occupies DAC_SCK_DIV clocks with SCK high in the second half.
  - spi_sdi changes only together with SCK falling.
  - At div_cnt==DAC_SCK_DIV-1:
    - if bit_cnt==FRAME_W-1: spi_cs_n<=1, dac_done<=1, go to CSH;
    - else: shift, next bit onto spi_sdi, bit_cnt++.
- Frame timing: spi_cs_n is low for exactly FRAME_W*DAC_SCK_DIV clocks (cycles 1..FRAME_W*DAC_SCK_DIV). It rises and dac_done pulses at cycle 1+FRAME_W*DAC_SCK_DIV.
- CSH:
  - Holds spi_cs_n=1, spi_sck=0 for CS_HIGH_CYC clocks.
  - On its last clock:
    - if a request is pending (or dac_dvalid=1 now): load it and enter SHIFT. spi_cs_n goes low next cycle and dac_busy stays 1.
    - else: go to IDLE; dac_busy=0 from the next cycle.
- Requests arriving while not in IDLE (SHIFT or CSH) go to a single-entry pending buffer:
  - if the buffer is empty: store.
  - if the buffer is full: overwrite with the newest value and pulse dac_drop for 1 cycle.
  - A frame already on the wire is never aborted or altered.
- Simultaneous events:
  - dac_dvalid on the last CSH clock with pending full: start the pending value; store the new one in the buffer; no drop.
  - dac_dvalid on the last CSH clock with pending empty: start the new value directly.
- dac_busy is 1 whenever state!=IDLE or pending is valid.
- Reset mid-frame: outputs go to reset values immediately (spi_cs_n=1 aborts the frame; the DAC discards partial frames). No dac_done pulse is generated.
- dac_din is ignored when dac_dvalid=0. Back-to-back accepted frames are separated by exactly CS_HIGH_CYC clocks of CS high.

Test Plan:
- Defaults; dac_din=10'h2AB pulsed at cycle 0:
  - shifted bits = 16'h3AAC, sampled on SCK rises;
  - spi_cs_n low cycles 1..128, rises at 129;
  - dac_done=1 at 129 only;
  - dac_busy 1 for cycles 1..130, 0 from 131;
  - 16 SCK pulses, each 4 clk high.
- dac_din=10'h3FF then 10'h000, second strobe at cycle 50:
  - frames 16'h3FFC then 16'h3000;
  - second CS falls at cycle 131;
  - no dac_drop; dac_busy never drops between frames.
- Three strobes (10'h001 at cycle 0, 10'h002 at cycle 10, 10'h003 at cycle 20):
  - dac_drop pulses at cycle 21;
  - frames sent are 16'h3004 then 16'h300C (10'h002 lost).
- Strobe exactly on the last CSH clock (cycle 130) after frame 1, with pending empty: the new frame's CS falls at cycle 131.
- Assert rst at cycle 60 during a frame:
  - spi_cs_n=1, spi_sck=0, dac_busy=0 immediately; no dac_done.
  - After release, a new strobe produces a full correct frame.
- DAC_SCK_DIV=2, CS_HIGH_CYC=1, dac_din=10'h155:
  - frame 16'h3554;
  - CS low 32 clocks; SCK toggles every clock;
  - dac_busy low 34 clocks after the strobe.
